shift_right_iter: RTL
=====================

SHIFT_RIGHT_ITER -- requirements
Module: shift_right_iter

Interface
REQ-001 Ports SHALL be exactly as follows, one per line: name  direction  width  meaning.
  clock       input   1   single clock; all state updates on rising edge.
  reset_n     input   1   asynchronous, active-low reset.
  start       input   1   request a shift; sampled on a clock edge.
  data_in     input   32  operand; captured when start is accepted.
  shamt       input   5   shift amount 0..31; captured when start is accepted.
  arith       input   1   1 = arithmetic right shift (SRA), 0 = logical right shift (SRL); captured when start is accepted.
  data_out    output  32  last completed result.
  data_ready  output  1   one-cycle pulse marking a new valid data_out.
  busy        output  1   high while an operation is in progress.
REQ-002 Parameters: none.

Function
REQ-003 States: IDLE, SHIFT, DONE.
REQ-004 busy SHALL be 1 whenever state is not IDLE.
REQ-005 In IDLE, if start=1 at an edge, the block SHALL:
  - capture data_in into the working register;
  - capture shamt into the remaining-count register;
  - capture arith, and fill bit = arith AND data_in[31];
  - move to SHIFT.
REQ-006 start SHALL be ignored when state is not IDLE; captured operands and the in-flight operation are unaffected.
REQ-007 On each edge in SHIFT, the block SHALL apply exactly one of these rules:
  - count >= 4: shift the working register right by 4, fill the top 4 bits with the fill bit, count -= 4.
  - 1 <= count <= 3: shift right by 1, fill bit 31 with the fill bit, count -= 1.
  - count = 0: copy the working register to data_out and move to DONE.
REQ-008 Shifted-out bits SHALL be discarded; the count never underflows.
REQ-009 Shift steps SHALL be n = floor(shamt/4) + (shamt mod 4); the maximum is n = 10 (shamt = 31).
REQ-010 In DONE, data_ready SHALL be 1 for exactly one cycle, then the state returns to IDLE unconditionally.
REQ-011 data_ready SHALL be high in the cycle following edge E0+n+1, where E0 is the accepting edge (total latency n+2 edges).
  - shamt = 0 gives latency 2 edges with data_out = data_in.
REQ-012 A start presented in the DONE cycle SHALL be ignored; a new start is accepted only from IDLE, so back-to-back throughput is one operation per n+3 cycles.
REQ-013 data_out SHALL change only on the transition from SHIFT to DONE and hold its value otherwise, including through IDLE.
REQ-014 The fill bit SHALL come from the captured operand, never from live data_in.
  - SRL always fills 0.
  - SRA with a positive operand fills 0.

Reset
REQ-015 While reset_n = 0, asynchronously and independent of clock, the block SHALL hold:
  - state = IDLE;
  - working register, count, and data_out = 0;
  - data_ready = 0, busy = 0.
REQ-016 Reset asserted mid-operation SHALL abort the operation without producing a data_ready pulse.
REQ-017 After reset_n rises, the first start SHALL be accepted at the first edge where start = 1.

Verification
REQ-018 data_in=0xF0000000, shamt=4, arith=1 -> data_out=0xFF000000, data_ready pulses 3 edges after acceptance, busy high for 3 cycles.
REQ-019 data_in=0x80000000, shamt=31, arith=0 -> data_out=0x00000001, data_ready 12 edges after acceptance.
REQ-020 data_in=0x80000001, shamt=13, arith=1 -> data_out=0xFFFC0000 after 6 edges; the same operands with arith=0 -> 0x00040000.
REQ-021 data_in=0x12345678, shamt=0 -> data_out=0x12345678 after 2 edges; start with data_in=0xFFFFFFFF, shamt=8 pulsed while busy -> no effect, single data_ready, data_out unchanged by the ignored request.
REQ-022 Start with shamt=31, then reset_n=0 at edge 5 -> busy=0, data_ready=0, data_out=0 immediately; no data_ready pulse follows reset release.
REQ-023 The bench SHALL compare every result against a reference model of SRL/SRA for all 32 shamt values with random operands, and check latency = n+2 for each.

Source files
------------

// File: rtl/shift_right_iter.sv
// Iterative 32-bit right shifter (SRL/SRA). Each SHIFT cycle moves the operand by 4 bits
// while at least 4 bits remain to be shifted, then by 1 bit; the result is published with a one-cycle pulse.
module shift_right_iter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] work;
  logic [4:0]  count;
  logic        fill;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == 5'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fill bit is frozen at capture so a changing data_in cannot disturb an in-flight SRA.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work     <= '0;
      count    <= '0;
      fill     <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= data_in;
            count <= shamt;
            fill  <= arith & data_in[31];
          end
        end
        SHIFT: begin
          if (count >= 5'd4) begin
            work  <= {{4{fill}}, work[31:4]};
            count <= count - 5'd4;
          end else if (count != 5'd0) begin
            work  <= {fill, work[31:1]};
            count <= count - 5'd1;
          end else begin
            data_out <= work;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign data_ready = (state == DONE);

endmodule
